// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   Owns the fetch program counter, issues word reads to instruction memory
//   over a req/ack handshake, buffers returned words in a small prefetch
//   queue and presents them to the core with valid/ready. A redirect from
//   the core flushes the queue and restarts fetch at the new address; a
//   response still in flight at that moment is dropped.
//
// Optional feature (macro IFU_PERF_CNT_EN):
//   Adds fetch_count (delivered instructions, wrapping) and drop_count
//   (discarded memory responses, saturating). Without the macro neither
//   port nor counter exists.
//
// Ports:
//   clk            in   1   system clock, rising edge
//   Reset          in   1   synchronous active-low reset
//   redirect_valid in   1   core requests a fetch restart
//   redirect_pc    in  32   restart address, bits [1:0] ignored
//   imem_req       out  1   read request to instruction memory
//   imem_addr      out 32   word address of the request
//   imem_ack       in   1   memory completes request, imem_rdata valid
//   imem_rdata     in  32   instruction word from memory
//   inst_valid     out  1   inst/PC hold a valid instruction
//   inst_ready     in   1   core accepts inst this cycle
//   inst           out 32   instruction word to core
//   PC             out 32   address of inst
//   fetch_count    out 32   (IFU_PERF_CNT_EN only)
//   drop_count     out 16   (IFU_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] PC
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0] fetch_count,
   output logic [15:0] drop_count
`endif
);

   localparam int            CW = $clog2(QDEPTH + 1);
   localparam logic [CW-1:0] QD = CW'(QDEPTH);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

   state_t        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          imem_req_q, imem_req_d;
   logic [31:0]   imem_addr_q, imem_addr_d;
   logic          inst_valid_q, inst_valid_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   q_inst_q [QDEPTH];
   logic [31:0]   q_inst_d [QDEPTH];
   logic [31:0]   q_pc_q   [QDEPTH];
   logic [31:0]   q_pc_d   [QDEPTH];

   logic          push, pop, discard;
   logic [CW-1:0] widx;
   logic [31:0]   redir_pc;
   logic          unused_rpc_lsbs;

   assign redir_pc        = {redirect_pc[31:2], 2'b00};
   assign unused_rpc_lsbs = ^redirect_pc[1:0];

   // Queue and FSM next-state. Redirect wins over pop and push in the same
   // cycle. Entry 0 is always the head so outputs come straight from flops.
   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      imem_req_d   = imem_req_q;
      imem_addr_d  = imem_addr_q;
      count_d      = count_q;
      q_inst_d     = q_inst_q;
      q_pc_d       = q_pc_q;
      widx         = '0;

      pop     = inst_valid_q & inst_ready & ~redirect_valid;
      push    = (state_q == S_REQ) & imem_ack & ~redirect_valid;
      discard = imem_ack & ((state_q == S_DROP) |
                            ((state_q == S_REQ) & redirect_valid));

      if (redirect_valid) begin
         count_d = '0;
      end else begin
         if (pop) begin
            for (int i = 0; i < QDEPTH - 1; i++) begin
               q_inst_d[i] = q_inst_q[i+1];
               q_pc_d[i]   = q_pc_q[i+1];
            end
         end
         // After a pop the first free slot moves down by one.
         widx = pop ? (count_q - CW'(1)) : count_q;
         for (int i = 0; i < QDEPTH; i++) begin
            if (push && (CW'(i) == widx)) begin
               q_inst_d[i] = imem_rdata;
               q_pc_d[i]   = fetch_pc_q;
            end
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end

      inst_valid_d = (count_d != '0);

      // Credit is judged on the post-push/pop occupancy, so a new request
      // is only launched if its word is guaranteed a queue slot.
      case (state_q)
         S_IDLE: begin
            if (redirect_valid) begin
               fetch_pc_d = redir_pc;
            end else if (count_d < QD) begin
               state_d     = S_REQ;
               imem_req_d  = 1'b1;
               imem_addr_d = fetch_pc_q;
            end
         end
         S_REQ: begin
            if (redirect_valid) begin
               fetch_pc_d = redir_pc;
               if (imem_ack) begin
                  state_d    = S_IDLE;
                  imem_req_d = 1'b0;
               end else begin
                  state_d = S_DROP;
               end
            end else if (imem_ack) begin
               fetch_pc_d = fetch_pc_q + 32'd4;
               if (count_d < QD) begin
                  imem_addr_d = fetch_pc_q + 32'd4;
               end else begin
                  state_d    = S_IDLE;
                  imem_req_d = 1'b0;
               end
            end
         end
         S_DROP: begin
            // Request stays up until memory answers; that answer is stale.
            if (redirect_valid) begin
               fetch_pc_d = redir_pc;
            end
            if (imem_ack) begin
               state_d    = S_IDLE;
               imem_req_d = 1'b0;
            end
         end
         default: begin
            state_d    = S_IDLE;
            imem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!Reset) begin
         state_q      <= S_IDLE;
         fetch_pc_q   <= RESET_PC;
         imem_req_q   <= 1'b0;
         imem_addr_q  <= RESET_PC;
         inst_valid_q <= 1'b0;
         count_q      <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            q_inst_q[i] <= 32'h0;
            q_pc_q[i]   <= RESET_PC;
         end
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         imem_req_q   <= imem_req_d;
         imem_addr_q  <= imem_addr_d;
         inst_valid_q <= inst_valid_d;
         count_q      <= count_d;
         q_inst_q     <= q_inst_d;
         q_pc_q       <= q_pc_d;
      end
   end

   assign imem_req   = imem_req_q;
   assign imem_addr  = imem_addr_q;
   assign inst_valid = inst_valid_q;
   assign inst       = q_inst_q[0];
   assign PC         = q_pc_q[0];

`ifdef IFU_PERF_CNT_EN
   logic [31:0] fetch_cnt_q;
   logic [15:0] drop_cnt_q;

   always_ff @(posedge clk) begin
      if (!Reset) begin
         fetch_cnt_q <= 32'h0;
         drop_cnt_q  <= 16'h0;
      end else begin
         if (pop) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         end
         if (discard && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
         end
      end
   end

   assign fetch_count = fetch_cnt_q;
   assign drop_count  = drop_cnt_q;
`else
   logic unused_discard;
   assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Purpose:
//   Directed bench for instr_fetch_unit. A behavioural memory answers each
//   request after a programmable number of wait cycles with a word derived
//   from its address (addr ^ 32'h5A5A_0000). A second instance with
//   RESET_PC = 32'hFFFF_FFF8 covers PC wrap-around.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        Reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] PC;

   logic        r1_Reset;
   logic        r1_req;
   logic [31:0] r1_addr;
   logic        r1_ack;
   logic [31:0] r1_rdata;
   logic        r1_valid;
   logic [31:0] r1_inst;
   logic [31:0] r1_pc;

`ifdef IFU_PERF_CNT_EN
   logic [31:0] fetch_count;
   logic [15:0] drop_count;
   logic [31:0] r1_fetch_count;
   logic [15:0] r1_drop_count;
`endif

   int unsigned wait_n;
   int unsigned wcnt;
   logic        stray_ack;
   int          checks;
   int          failures;
   int          nack;

   always #5 clk = ~clk;

   function automatic logic [31:0] memword(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   // Memory: ack once the request has waited wait_n cycles.
   always @(posedge clk) begin
      if (!imem_req || imem_ack) wcnt <= 0;
      else                       wcnt <= wcnt + 1;
   end
   assign imem_ack   = (imem_req && (wcnt == wait_n)) || stray_ack;
   assign imem_rdata = memword(imem_addr);

   assign r1_ack   = r1_req;
   assign r1_rdata = memword(r1_addr);

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
      .clk(clk), .Reset(Reset),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst(inst), .PC(PC)
`ifdef IFU_PERF_CNT_EN
      , .fetch_count(fetch_count), .drop_count(drop_count)
`endif
   );

   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(2)) dut_wrap (
      .clk(clk), .Reset(r1_Reset),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .imem_req(r1_req), .imem_addr(r1_addr),
      .imem_ack(r1_ack), .imem_rdata(r1_rdata),
      .inst_valid(r1_valid), .inst_ready(1'b1),
      .inst(r1_inst), .PC(r1_pc)
`ifdef IFU_PERF_CNT_EN
      , .fetch_count(r1_fetch_count), .drop_count(r1_drop_count)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0; failures = 0;
      Reset = 1'b0; r1_Reset = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      inst_ready = 1'b1; wait_n = 0; stray_ack = 1'b0;

      // Reset state
      tick(); tick();
      check("rst_req",   {31'b0, imem_req},   32'd0);
      check("rst_valid", {31'b0, inst_valid}, 32'd0);
      check("rst_inst",  inst,                32'h0);
      check("rst_pc",    PC,                  32'h0);
      check("rst_addr",  imem_addr,           32'h0);

      // Zero-wait streaming, one instruction per cycle
      Reset = 1'b1;
      tick();
      check("s_req1",  {31'b0, imem_req}, 32'd1);
      check("s_addr0", imem_addr,         32'h0);
      tick();
      check("s_valid0", {31'b0, inst_valid}, 32'd1);
      check("s_pc0",    PC,                  32'h0);
      check("s_inst0",  inst,                32'h5A5A_0000);
      check("s_addr4",  imem_addr,           32'h4);
      tick();
      check("s_pc4",   PC,        32'h4);
      check("s_inst4", inst,      32'h5A5A_0004);
      check("s_addr8", imem_addr, 32'h8);
      tick();
      check("s_pc8",   PC,        32'h8);
      check("s_inst8", inst,      32'h5A5A_0008);

      // Back-pressure: only QDEPTH words fetched, head held
      Reset = 1'b0; tick();
      Reset = 1'b1; inst_ready = 1'b0;
      tick();
      nack = 0;
      for (int i = 0; i < 10; i++) begin
         if (imem_req && imem_ack) nack++;
         tick();
      end
      check("bp_nack",  nack,                2);
      check("bp_req",   {31'b0, imem_req},   32'd0);
      check("bp_valid", {31'b0, inst_valid}, 32'd1);
      check("bp_inst",  inst,                32'h5A5A_0000);
      check("bp_pc",    PC,                  32'h0);

      // Redirect during a 3-cycle wait drops the outstanding word
      Reset = 1'b0; tick();
      Reset = 1'b1; wait_n = 3;
      tick();
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
      tick();
      redirect_valid = 1'b0;
      check("dr_req_held",  {31'b0, imem_req},   32'd1);
      check("dr_addr_held", imem_addr,           32'h0);
      check("dr_valid",     {31'b0, inst_valid}, 32'd0);
      tick();
      tick();
      check("dr_req_low", {31'b0, imem_req},   32'd0);
      check("dr_nodata",  {31'b0, inst_valid}, 32'd0);
      wait_n = 0;
      tick();
      check("dr_req_new",  {31'b0, imem_req}, 32'd1);
      check("dr_addr_new", imem_addr,         32'h100);
      tick();
      check("dr_valid_new", {31'b0, inst_valid}, 32'd1);
      check("dr_pc_new",    PC,                  32'h100);
      check("dr_inst_new",  inst,                32'h5A5A_0100);
`ifdef IFU_PERF_CNT_EN
      check("dr_dropcnt", {16'b0, drop_count}, 32'd1);
`endif

      // Redirect coincident with ack and pop
      inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
      tick();
      redirect_valid = 1'b0;
      check("rc_valid", {31'b0, inst_valid}, 32'd0);
      check("rc_req",   {31'b0, imem_req},   32'd0);
      tick();
      check("rc_addr",   imem_addr,           32'h200);
      check("rc_valid2", {31'b0, inst_valid}, 32'd0);
      tick();
      check("rc_valid3", {31'b0, inst_valid}, 32'd1);
      check("rc_pc",     PC,                  32'h200);
      check("rc_inst",   inst,                32'h5A5A_0200);
`ifdef IFU_PERF_CNT_EN
      check("rc_fetchcnt0", fetch_count,          32'd0);
      check("rc_dropcnt",   {16'b0, drop_count},  32'd2);
`endif
      tick();
      check("rc_pc2", PC, 32'h204);
`ifdef IFU_PERF_CNT_EN
      check("rc_fetchcnt1", fetch_count, 32'd1);
`endif

      // PC wrap on the second instance
      r1_Reset = 1'b1;
      tick();
      check("wr_addr", r1_addr, 32'hFFFF_FFF8);
      tick();
      check("wr_pc0",   r1_pc,   32'hFFFF_FFF8);
      check("wr_inst0", r1_inst, 32'hA5A5_FFF8);
      tick();
      check("wr_pc1", r1_pc, 32'hFFFF_FFFC);
      tick();
      check("wr_pc2",   r1_pc,   32'h0000_0000);
      check("wr_inst2", r1_inst, 32'h5A5A_0000);

      // Reset while a request is outstanding, then a stray ack
      Reset = 1'b0; tick();
      Reset = 1'b1; wait_n = 3;
      tick();
      tick();
      Reset = 1'b0;
      tick();
      check("rm_req",   {31'b0, imem_req},   32'd0);
      check("rm_valid", {31'b0, inst_valid}, 32'd0);
      check("rm_addr",  imem_addr,           32'h0);
`ifdef IFU_PERF_CNT_EN
      check("rm_fetchcnt", fetch_count, 32'd0);
`endif
      tick();
      wait_n = 0; stray_ack = 1'b1; Reset = 1'b1;
      tick();
      stray_ack = 1'b0;
      check("rm_stray_valid", {31'b0, inst_valid}, 32'd0);
      check("rm_restart_req", {31'b0, imem_req},   32'd1);
      check("rm_restart_adr", imem_addr,           32'h0);
      tick();
      check("rm_pc",   PC,   32'h0);
      check("rm_inst", inst, 32'h5A5A_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
